// File: rtl/rv_core_pkg.sv
// Shared definitions for the RISC-V core front end: NOP encoding, reset PC,
// fetch FSM states and a word-alignment helper.
// Build option MISALIGN_CHECK_EN adds the FAULT fetch state.
package rv_core_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_REQ   = 3'd1,
    FETCH_WAIT  = 3'd2,
    FETCH_HOLD  = 3'd3,
    FETCH_DRAIN = 3'd4
`ifdef MISALIGN_CHECK_EN
    , FETCH_FAULT = 3'd5
`endif
  } fetch_state_e;

  // Clear the byte-offset bits of an address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter and next-PC select (redirect > +4 advance > hold).
// Latency: pc_nxt_o is combinational, the PC register updates on the next edge.
// Backpressure: none; the caller only asserts advance_i on an accepted request.
// Redirect targets are always forced word-aligned; with MISALIGN_CHECK_EN a
// misaligned target is also reported on misalign_o.
module fetch_pc_gen
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        advance_i,
  output logic [31:0] pc_nxt_o
`ifdef MISALIGN_CHECK_EN
  , output logic      misalign_o
`endif
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Next-PC select: a redirect overrides the sequential +4 (which wraps at 2^32).
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = word_align(redirect_pc_i);
    end else if (advance_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_nxt_o = pc_d;

`ifdef MISALIGN_CHECK_EN
  assign misalign_o = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem req/gnt/rvalid, presented instr.
// Latency: zero-wait memory gives instr_valid 2 cycles after the request, 1 per 2 cycles.
// Backpressure: stall at response time parks in HOLD with outputs frozen, no new request.
// Build option MISALIGN_CHECK_EN: misaligned redirect -> sticky fault, fetch halts.
module instr_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_op_1,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        misalign_fault
);

  fetch_state_e state_q;
  logic         flush_q;   // the response still owed by memory is stale
  logic         req_q;
  logic [31:0]  addr_q;    // address of the in-flight request, distinct from the PC
  logic [31:0]  op_q;
  logic [31:0]  ipc_q;
  logic         valid_q;

  logic         redirect_ok;
  logic         advance;
  logic [31:0]  pc_nxt;

`ifdef MISALIGN_CHECK_EN
  logic         misalign;
  logic         fault_q;
  // Once faulted the unit is dead until reset, so redirects are ignored.
  assign redirect_ok = redirect && (state_q != FETCH_FAULT);
`else
  assign redirect_ok = redirect;
`endif

  // The PC only moves forward when memory accepts a request issued from REQ;
  // the grant that ends DRAIN belongs to a stale address and must not advance.
  assign advance = (state_q == FETCH_REQ) && imem_gnt;

  fetch_pc_gen #(
    .RESET_PC      (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_ok),
    .redirect_pc_i (redirect_pc),
    .advance_i     (advance),
    .pc_nxt_o      (pc_nxt)
`ifdef MISALIGN_CHECK_EN
    , .misalign_o  (misalign)
`endif
  );

  // Fetch sequencing, request handshake and the presented-instruction register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_IDLE;
      flush_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      op_q    <= NOP_INSTR;
      ipc_q   <= RESET_PC;
      valid_q <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      // A presented instruction is consumed whenever downstream is not stalled.
      if (valid_q && !stall) begin
        valid_q <= 1'b0;
        op_q    <= NOP_INSTR;
      end

      case (state_q)
        FETCH_IDLE: begin
          state_q <= FETCH_REQ;
          req_q   <= 1'b1;
          addr_q  <= pc_nxt;
        end
        FETCH_REQ: begin
          // A request already on the bus cannot be withdrawn; a redirect just
          // marks its eventual response as stale.
          if (redirect_ok) begin
            flush_q <= 1'b1;
          end
          if (imem_gnt) begin
            state_q <= FETCH_WAIT;
            req_q   <= 1'b0;
          end else if (redirect_ok) begin
            state_q <= FETCH_DRAIN;
          end
        end
        FETCH_DRAIN: begin
          if (imem_gnt) begin
            state_q <= FETCH_WAIT;
            req_q   <= 1'b0;
          end
        end
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            flush_q <= 1'b0;
            if (!flush_q && !redirect_ok) begin
              valid_q <= 1'b1;
              op_q    <= imem_rdata;
              ipc_q   <= addr_q;
            end
            if (!flush_q && !redirect_ok && stall) begin
              state_q <= FETCH_HOLD;
            end else begin
              state_q <= FETCH_REQ;
              req_q   <= 1'b1;
              addr_q  <= pc_nxt;
            end
          end else if (redirect_ok) begin
            flush_q <= 1'b1;
          end
        end
        FETCH_HOLD: begin
          if (redirect_ok || !stall) begin
            state_q <= FETCH_REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_nxt;
          end
        end
        default: begin
        end
      endcase

      // A redirect squashes whatever is presented, including a stalled one.
      if (redirect_ok) begin
        valid_q <= 1'b0;
        op_q    <= NOP_INSTR;
      end

`ifdef MISALIGN_CHECK_EN
      // Misaligned target: stop fetching for good and drop any response.
      if (redirect_ok && misalign) begin
        state_q <= FETCH_FAULT;
        req_q   <= 1'b0;
        flush_q <= 1'b0;
        fault_q <= 1'b1;
      end
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_op_1  = op_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
`ifdef MISALIGN_CHECK_EN
  assign misalign_fault = fault_q;
`else
  assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural instruction memory with programmable
// grant/response delays, address and instruction scoreboards, table-driven
// fetch runs plus hand-written stall, redirect, drain and reset sequences.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instr_op_1;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        misalign_fault;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_op_1     (instr_op_1),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .misalign_fault (misalign_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] op;
  } sb_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_addr_q[$];
  sb_t         exp_instr_q[$];
  int          rise_q[$];

  int gnt_dly = 0;
  int rv_dly = 1;
  int gnt_budget = 0;
  int gnt_cnt = 0;
  int wait_cnt = 0;
  int pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] held_addr = '0;
  bit req_seen = 1'b0;
  int first_req_cyc = 0;
  bit prev_valid = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[3:0], 8'h00, a[15:4], 8'h33};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a);
    sb_t e;
    e.pc = a;
    e.op = mem_data(a);
    exp_instr_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Instruction memory: grants after gnt_dly waiting cycles, answers rv_dly later.
  initial forever begin
    @(posedge clk);
    #2;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata = mem_data(pend_addr);
      end
    end
    if (rst) begin
      wait_cnt = 0;
    end else if (imem_req && pend_cnt == 0 && gnt_budget > 0) begin
      if (wait_cnt == 0) held_addr = imem_addr;
      else chk("addr_stable", imem_addr, held_addr);
      if (wait_cnt >= gnt_dly) begin
        imem_gnt = 1'b1;
        pend_cnt = rv_dly;
        pend_addr = imem_addr;
        wait_cnt = 0;
        gnt_budget--;
        gnt_cnt++;
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL addr_extra: got grant at %h expected no request", imem_addr);
        end else begin
          chk("imem_addr", imem_addr, exp_addr_q.pop_front());
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // Output monitor: consumed instructions against the scoreboard, NOP when idle.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (imem_req && !req_seen) begin
        req_seen = 1'b1;
        first_req_cyc = cyc;
      end
      if (instr_valid && !prev_valid) rise_q.push_back(cyc);
      prev_valid = instr_valid;
      if (instr_valid && !stall) begin
        if (exp_instr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL instr_extra: got pc %h op %h expected none", instr_pc, instr_op_1);
        end else begin
          sb_t e;
          e = exp_instr_q.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr_op", instr_op_1, e.op);
        end
      end else if (!instr_valid) begin
        chk("nop_idle", instr_op_1, NOP);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1);
  end

  task automatic check_reset();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_op", instr_op_1, NOP);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_fault", misalign_fault, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    gnt_budget = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset();
    exp_addr_q.delete();
    exp_instr_q.delete();
    rise_q.delete();
    req_seen = 1'b0;
    gnt_cnt = 0;
  endtask

  // Release reset, optionally redirecting during the IDLE cycle.
  task automatic release_rst(input bit redir, input logic [31:0] tgt,
                             input bit exp_req, input logic [31:0] exp_addr);
    @(posedge clk);
    #1;
    rst = 1'b0;
    redirect = redir;
    redirect_pc = tgt;
    @(negedge clk);
    chk("idle_req", imem_req, 0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("first_req", imem_req, exp_req);
    if (exp_req) chk("first_addr", imem_addr, exp_addr);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_instr_q.size() == 0 && exp_addr_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drained", exp_instr_q.size() + exp_addr_q.size(), 0);
  endtask

  typedef struct {
    bit          redir;
    logic [31:0] target;
    int          gd;
    int          rd;
    int          exp_period;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t tbl[5];
    logic [31:0] a;
    logic [31:0] h_pc;
    logic [31:0] h_op;

    tbl[0] = '{1'b0, 32'h0000_0000, 0, 1, 2, 2};
    tbl[1] = '{1'b1, 32'h0000_0040, 2, 1, 4, 4};
    tbl[2] = '{1'b1, 32'h0000_0080, 0, 3, 4, 4};
    tbl[3] = '{1'b1, 32'hFFFF_FFF8, 1, 2, 4, 4};
    tbl[4] = '{1'b1, 32'h0000_1000, 0, 1, 2, 2};

    // Sequential fetch runs: addresses, data, throughput and latency.
    for (int r = 0; r < 5; r++) begin
      do_reset();
      gnt_dly = tbl[r].gd;
      rv_dly = tbl[r].rd;
      for (int k = 0; k < 4; k++) begin
        a = tbl[r].target + 32'(4 * k);
        exp_addr_q.push_back(a);
        push_fetch(a);
      end
      gnt_budget = 4;
      release_rst(tbl[r].redir, tbl[r].target, 1'b1, tbl[r].target);
      wait_drain(100);
      chk("rise_count", (rise_q.size() >= 3) ? 32'd1 : 32'd0, 1);
      if (rise_q.size() >= 3) begin
        chk("period_a", rise_q[1] - rise_q[0], tbl[r].exp_period);
        chk("period_b", rise_q[2] - rise_q[1], tbl[r].exp_period);
        chk("latency", rise_q[0] - first_req_cyc, tbl[r].exp_lat);
      end
    end

    // Stall while presenting: outputs frozen, no request until stall drops.
    do_reset();
    gnt_dly = 0;
    rv_dly = 1;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    push_fetch(32'h0);
    push_fetch(32'h4);
    gnt_budget = 2;
    release_rst(1'b0, 32'h0, 1'b1, 32'h0);
    for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
    chk("stall_first_valid", instr_valid, 1);
    @(posedge clk);
    #1;
    stall = 1'b1;
    @(posedge clk);
    @(negedge clk);
    h_pc = instr_pc;
    h_op = instr_op_1;
    chk("stall_pc", h_pc, 32'h4);
    chk("stall_op", h_op, mem_data(32'h4));
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_valid", instr_valid, 1);
      chk("stall_hold_pc", instr_pc, h_pc);
      chk("stall_hold_op", instr_op_1, h_op);
      chk("stall_no_req", imem_req, 0);
      @(posedge clk);
    end
    #1;
    stall = 1'b0;
    @(negedge clk);
    chk("stall_release_req", imem_req, 0);
    @(posedge clk);
    #1;
    chk("req_after_stall", imem_req, 1);
    chk("addr_after_stall", imem_addr, 32'h8);
    wait_drain(50);

    // Redirect while waiting for the 0x8 response.
    do_reset();
    gnt_dly = 0;
    rv_dly = 3;
    exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'h100};
    push_fetch(32'h0);
    push_fetch(32'h4);
    push_fetch(32'h100);
    gnt_budget = 4;
    release_rst(1'b0, 32'h0, 1'b1, 32'h0);
    for (int i = 0; i < 50 && gnt_cnt < 3; i++) @(negedge clk);
    chk("wait_gnt8", gnt_cnt, 3);
    @(posedge clk);
    #1;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("redir_valid", instr_valid, 0);
    wait_drain(60);

    // Grant withheld 4 cycles with a redirect to 0x200 in between.
    do_reset();
    gnt_dly = 4;
    rv_dly = 1;
    exp_addr_q = '{32'h0, 32'h200, 32'h204};
    push_fetch(32'h200);
    push_fetch(32'h204);
    gnt_budget = 3;
    release_rst(1'b0, 32'h0, 1'b1, 32'h0);
    @(posedge clk);
    #1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("drain_req", imem_req, 1);
    chk("drain_addr", imem_addr, 32'h0);
    wait_drain(80);

    // Reset during WAIT with the response arriving the following cycle.
    do_reset();
    gnt_dly = 0;
    rv_dly = 2;
    exp_addr_q.push_back(32'h0);
    gnt_budget = 1;
    release_rst(1'b0, 32'h0, 1'b1, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("late_rvalid_ignored", instr_valid, 0);
    end
    chk("late_addr_left", exp_addr_q.size(), 0);

    // Misaligned redirect target.
    do_reset();
    gnt_dly = 0;
    rv_dly = 1;
`ifdef MISALIGN_CHECK_EN
    gnt_budget = 2;
    release_rst(1'b1, 32'h102, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fault_flag", misalign_fault, 1);
      chk("fault_no_req", imem_req, 0);
      chk("fault_valid", instr_valid, 0);
    end
`else
    exp_addr_q = '{32'h100, 32'h104};
    push_fetch(32'h100);
    push_fetch(32'h104);
    gnt_budget = 2;
    release_rst(1'b1, 32'h102, 1'b1, 32'h100);
    wait_drain(40);
    chk("no_fault", misalign_fault, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the RISC-V core. Holds the program counter and fetches 32-bit instructions from instruction memory over a request/grant/response handshake. Presents each instruction with its PC to the control path decoder (`instr_op_1`) and the datapath. Accepts branch redirects from the execute/branch logic. Supports at most one outstanding memory request.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; must be word-aligned.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; word-aligned; stable while `imem_req && !imem_gnt`.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid; arrives at least one cycle after the grant.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  downstream cannot consume the presented instruction.
- `redirect`  in  1  taken branch/jump; load `redirect_pc`.
- `redirect_pc`  in  32  branch target.
- `instr_op_1`  out  32  presented instruction; NOP (32'h0000_0013) when not valid.
- `instr_pc`  out  32  PC of the presented instruction.
- `instr_valid`  out  1  `instr_op_1`/`instr_pc` hold a real instruction.
- `misalign_fault`  out  1  sticky misaligned-target flag (see Configuration).

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `imem_addr`: address of the in-flight request, separate from `pc`.
  - Output register: `instr_op_1`, `instr_pc`, `instr_valid`.
  - `flush`: in-flight response is stale.
- FSM states: IDLE, REQ, WAIT, HOLD, DRAIN, FAULT.
- IDLE: entered from reset; lasts one cycle, then REQ.
- REQ:
  - `imem_req`=1, `imem_addr`=captured `pc`.
  - On `imem_gnt`, go to WAIT and set `pc` <= `pc`+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
  - Without `imem_gnt`, stay in REQ with address unchanged.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid` with `flush`=0: load the output register (`instr_valid`=1, `instr_pc`=`imem_addr`). Go to HOLD if `stall`, else REQ.
  - On `imem_rvalid` with `flush`=1: discard the data, clear `flush`, go to REQ.
- HOLD: outputs held unchanged while `stall`=1; when `stall`=0, go to REQ.
- Consumption: an instruction is consumed in any cycle with `instr_valid && !stall`. `instr_valid` clears the next cycle unless a new response loads the register that same cycle.
- Redirect handling (highest priority, any state except FAULT):
  - `pc` <= `redirect_pc`, and `instr_valid` <= 0 next cycle (NOP presented).
  - REQ with `imem_gnt`=0: the request is not withdrawn. Set `flush` and go to DRAIN after the grant.
  - REQ with `imem_gnt`=1: `pc` takes `redirect_pc` (not +4); set `flush`; go to WAIT.
  - WAIT: set `flush`.
  - HOLD: go to REQ.
- DRAIN: hold `imem_req` until `imem_gnt`, then go to WAIT with `flush`=1.
- Redirect and `stall` in the same cycle: redirect wins.
- `rvalid` and `redirect` in the same cycle: the response is discarded.
- `imem_rvalid` outside WAIT is ignored.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `pc`=`RESET_PC`, `instr_op_1`=32'h0000_0013, `instr_pc`=`RESET_PC`, `instr_valid`=0, `misalign_fault`=0, state IDLE, `flush`=0.
- First `imem_req` occurs in the second rising edge after `rst` deasserts.
- With a zero-wait memory (gnt in the REQ cycle, rvalid the next cycle), `instr_valid` rises one cycle after `rvalid`. Throughput is one instruction per 2 cycles; latency from request to valid is 2 cycles.
- Redirect latency: the first fetch at the target is issued 1 cycle after the redirect cycle from WAIT/HOLD, or after the stale response drains.
- Reset asserted mid-operation clears all state immediately; a late `rvalid` after reset is ignored (state is IDLE).
- All outputs are driven from registers; no combinational path from inputs to outputs.

## Configuration
- `MISALIGN_CHECK_EN` defined:
  - A `redirect` with `redirect_pc[1:0]` != 0 sets `misalign_fault`=1 (sticky until `rst`).
  - The block enters FAULT: `imem_req`=0, `instr_valid`=0, and any in-flight response is discarded. It leaves FAULT only via reset.
- `MISALIGN_CHECK_EN` undefined: `redirect_pc[1:0]` is forced to 0, `misalign_fault` is tied to 0, and the FAULT state is not compiled.

## Structure
- Shared package `rv_core_pkg`:
  - NOP constant 32'h0000_0013.
  - Fetch FSM state enum.
  - Default reset PC constant.
- One natural sub-module, `fetch_pc_gen`: the `pc` register and next-PC mux (+4 / redirect / hold), with alignment forcing and checking.

## Test plan
- Reset release, zero-wait memory returning 32'h0000_0033 at 0x0 and 32'h4000_0033 at 0x4 -> `imem_addr` 0x0 then 0x4; `instr_valid` pulses with `instr_pc` 0x0 then 0x4; `instr_op_1` = NOP between valid instructions.
- `stall`=1 for 3 cycles while an instruction is presented -> outputs held identically and no new `imem_req` until `stall` drops.
- `redirect` to 0x100 while in WAIT for 0x8 -> the 0x8 response is discarded and the next `imem_addr` is 0x100.
- `imem_gnt` withheld 4 cycles plus a redirect to 0x200 during the wait -> `imem_addr` stays at the old address until the grant, its data is dropped, then 0x200 is fetched.
- `rst` asserted while in WAIT, with `rvalid` the next cycle -> all outputs at reset values and no instruction is presented.
- With `MISALIGN_CHECK_EN`, redirect to 0x102 -> `misalign_fault`=1 and `imem_req` stays 0 thereafter; without the macro -> the fetch is issued at 0x100.
